// File: rtl/dice_roller_pkg.sv
// Shared types and helpers for the dice roller: FSM states, LFSR taps and the
// LFSR-to-face mapping used by the spin and settle phases.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROLLING,
        SETTLE,
        HOLD
    } state_t;

    localparam int FACES = 6;
    localparam int LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8;

    // Fibonacci step: shift toward the MSB and feed the tap parity into bit 0.
    // Bit 7 is a tap, so the update is invertible and a nonzero seed never reaches 0.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] face_of(input logic [LFSR_WIDTH-1:0] s);
        return 8'(s % LFSR_WIDTH'(FACES)) + 8'd1;
    endfunction

endpackage

// File: rtl/dice_roller_debouncer.sv
// Roll-button input path: 2-flop synchronizer, stability counter and
// registered press/release pulses derived from the debounced level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // NOTE: every flop here uses <= so each one samples the pre-edge value of its source.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            level         <= 1'b0;
            level_q       <= 1'b0;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= btn;
            sync2         <= sync1;
            level_q       <= level;
            press_pulse   <= level & ~level_q;
            release_pulse <= ~level & level_q;

            // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dice_roller.sv
// Dice roller: debounced roll button drives a spin/settle FSM that samples a
// free-running LFSR into a registered 1..6 face and counts completed rolls.
module dice_roller
    import dice_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES  = 500000,
    parameter int               SPIN_STEP_CYCLES = 2500000,
    parameter int               SETTLE_STEPS     = 8,
    parameter logic [7:0]       LFSR_SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_btn,
    input  logic       enable,
    output logic [7:0] roll_value,
    output logic       rolling,
    output logic       roll_done,
    output logic [7:0] roll_count
);

    localparam int TW = $clog2(SPIN_STEP_CYCLES);
    localparam int SW = $clog2(SETTLE_STEPS + 1);

    state_t                state;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [TW-1:0]         step_timer;
    logic [SW-1:0]         settle_cnt;
    logic                  press_pulse;
    logic                  release_pulse;
    logic                  tick;
    logic [7:0]            face;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .reset        (reset),
        .btn          (roll_btn),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    assign tick = (step_timer == TW'(SPIN_STEP_CYCLES - 1));
    assign face = face_of(lfsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            step_timer <= '0;
            settle_cnt <= '0;
            roll_value <= 8'd0;
            rolling    <= 1'b0;
            roll_done  <= 1'b0;
            roll_count <= 8'd0;
        end else begin
            lfsr       <= lfsr_next(lfsr);
            step_timer <= tick ? '0 : step_timer + TW'(1);
            roll_done  <= 1'b0;

            case (state)
                IDLE, HOLD: begin
                    if (press_pulse && enable) begin
                        state      <= ROLLING;
                        rolling    <= 1'b1;
                        step_timer <= '0;
                    end
                end

                ROLLING: begin
                    if (tick) begin
                        roll_value <= face;
                    end
                    // The step timer keeps its phase across the move into SETTLE.
                    if (release_pulse) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end

                SETTLE: begin
                    if (tick) begin
                        roll_value <= face;
                        if (settle_cnt == SW'(SETTLE_STEPS - 1)) begin
                            state      <= HOLD;
                            rolling    <= 1'b0;
                            roll_done  <= 1'b1;
                            roll_count <= roll_count + 8'd1;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: two instances (spin step 3 and 2) share all
// inputs; the second is checked cycle by cycle against an LFSR reference model.
module tb_dice_roller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       roll_btn = 1'b0;
    logic       enable = 1'b1;

    logic [7:0] a_value, a_count, b_value, b_count;
    logic       a_rolling, a_done, b_rolling, b_done;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] model_lfsr = 8'hA5;
    logic [7:0] last_face = 8'd0;

    always #5 clk = ~clk;

    dice_roller #(
        .DEBOUNCE_CYCLES(4), .SPIN_STEP_CYCLES(3), .SETTLE_STEPS(2), .LFSR_SEED(8'hA5)
    ) dut_a (
        .clk(clk), .reset(reset), .roll_btn(roll_btn), .enable(enable),
        .roll_value(a_value), .rolling(a_rolling), .roll_done(a_done), .roll_count(a_count)
    );

    dice_roller #(
        .DEBOUNCE_CYCLES(4), .SPIN_STEP_CYCLES(2), .SETTLE_STEPS(2), .LFSR_SEED(8'hA5)
    ) dut_b (
        .clk(clk), .reset(reset), .roll_btn(roll_btn), .enable(enable),
        .roll_value(b_value), .rolling(b_rolling), .roll_done(b_done), .roll_count(b_count)
    );

    function automatic logic [7:0] model_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] model_face(input logic [7:0] s);
        return 8'(int'(s) % 6 + 1);
    endfunction

    // last_face holds the face of the LFSR state that was present just before the latest edge.
    always @(posedge clk) begin
        last_face  <= model_face(model_lfsr);
        model_lfsr <= reset ? 8'hA5 : model_next(model_lfsr);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        roll_btn = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Edge e is the e-th posedge after the call; the button is high for edges 0..hold-1.
    task automatic run_roll(input int hold, input logic [7:0] prev_val,
                            output int rise_e, output int first_upd_e, output int done_e,
                            output int pulses, output logic [7:0] done_val,
                            output bit stable_ok, output bit range_ok);
        rise_e = -1; first_upd_e = -1; done_e = -1; pulses = 0;
        done_val = 8'd0; stable_ok = 1'b1; range_ok = 1'b1;
        for (int e = 0; e < hold + 25; e++) begin
            roll_btn = (e < hold);
            step();
            if (a_rolling === 1'b1 && rise_e < 0) rise_e = e;
            if (a_value !== prev_val && first_upd_e < 0) first_upd_e = e;
            if (a_done === 1'b1) begin
                pulses++;
                if (done_e < 0) begin
                    done_e = e;
                    done_val = a_value;
                end
            end
            if (rise_e < 0 && a_value !== prev_val) stable_ok = 1'b0;
            if (done_e >= 0 && a_value !== done_val) stable_ok = 1'b0;
            if (a_value > 8'd6 || (first_upd_e >= 0 && a_value == 8'd0)) range_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        compared++; if (a_value !== 8'd0) begin mismatched++; $display("FAIL reset_value: got %0d expected 0", a_value); end
        compared++; if (a_rolling !== 1'b0) begin mismatched++; $display("FAIL reset_rolling: got %b expected 0", a_rolling); end
        compared++; if (a_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", a_done); end
        compared++; if (a_count !== 8'd0) begin mismatched++; $display("FAIL reset_count: got %0d expected 0", a_count); end
    endtask

    task automatic test_bounce();
        bit activity = 1'b0;
        for (int i = 0; i < 40; i++) begin
            roll_btn = (i < 20) ? ~i[0] : 1'b0;
            step();
            if (a_rolling !== 1'b0 || a_done !== 1'b0 || b_rolling !== 1'b0) activity = 1'b1;
        end
        compared++; if (activity) begin mismatched++; $display("FAIL bounce_activity: got 1 expected 0"); end
        compared++; if (a_value !== 8'd0) begin mismatched++; $display("FAIL bounce_value: got %0d expected 0", a_value); end
        compared++; if (a_count !== 8'd0) begin mismatched++; $display("FAIL bounce_count: got %0d expected 0", a_count); end
    endtask

    task automatic test_enable_gating();
        bit activity = 1'b0;
        int rise_e, upd_e, done_e, pulses;
        logic [7:0] dv;
        bit stable_ok, range_ok;

        apply_reset();
        enable = 1'b0;
        for (int e = 0; e < 60; e++) begin
            roll_btn = (e < 20);
            step();
            if (a_rolling !== 1'b0 || a_done !== 1'b0 || a_value !== 8'd0) activity = 1'b1;
        end
        compared++; if (activity) begin mismatched++; $display("FAIL gated_idle_activity: got 1 expected 0"); end

        enable = 1'b1;
        run_roll(20, 8'd0, rise_e, upd_e, done_e, pulses, dv, stable_ok, range_ok);
        compared++; if (rise_e !== 7) begin mismatched++; $display("FAIL enabled_rise: got %0d expected 7", rise_e); end
        compared++; if (done_e !== 31) begin mismatched++; $display("FAIL enabled_done_edge: got %0d expected 31", done_e); end
        compared++; if (a_count !== 8'd1) begin mismatched++; $display("FAIL enabled_count: got %0d expected 1", a_count); end

        // A press in HOLD while the game forbids rolling is dropped.
        activity = 1'b0;
        enable = 1'b0;
        for (int e = 0; e < 40; e++) begin
            roll_btn = (e < 20);
            step();
            if (a_rolling !== 1'b0 || a_done !== 1'b0 || a_value !== dv) activity = 1'b1;
        end
        enable = 1'b1;
        compared++; if (activity) begin mismatched++; $display("FAIL gated_hold_activity: got 1 expected 0"); end
        compared++; if (a_count !== 8'd1) begin mismatched++; $display("FAIL gated_hold_count: got %0d expected 1", a_count); end
    endtask

    task automatic test_basic_roll();
        int rise_e, upd_e, done_e, pulses;
        logic [7:0] dv;
        bit stable_ok, range_ok;

        apply_reset();
        run_roll(30, 8'd0, rise_e, upd_e, done_e, pulses, dv, stable_ok, range_ok);
        compared++; if (rise_e !== 7) begin mismatched++; $display("FAIL basic_rise: got %0d expected 7", rise_e); end
        compared++; if (upd_e !== 10) begin mismatched++; $display("FAIL basic_first_tick: got %0d expected 10", upd_e); end
        compared++; if (done_e !== 43) begin mismatched++; $display("FAIL basic_done_edge: got %0d expected 43", done_e); end
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL basic_done_pulses: got %0d expected 1", pulses); end
        compared++; if (a_count !== 8'd1) begin mismatched++; $display("FAIL basic_count: got %0d expected 1", a_count); end
        compared++; if (a_rolling !== 1'b0) begin mismatched++; $display("FAIL basic_rolling_after: got %b expected 0", a_rolling); end
        compared++; if (dv < 8'd1 || dv > 8'd6) begin mismatched++; $display("FAIL basic_face_range: got %0d expected 1..6", dv); end
        compared++; if (!range_ok) begin mismatched++; $display("FAIL basic_value_range: got out-of-range expected 0..6"); end
        compared++; if (!stable_ok) begin mismatched++; $display("FAIL basic_stability: got unstable expected stable"); end
    endtask

    task automatic test_reset_mid_roll();
        bit activity = 1'b0;
        int pulses = 0;

        apply_reset();
        for (int e = 0; e <= 28; e++) begin
            roll_btn = (e < 20);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++; if (a_value !== 8'd0) begin mismatched++; $display("FAIL midreset_value: got %0d expected 0", a_value); end
        compared++; if (a_rolling !== 1'b0) begin mismatched++; $display("FAIL midreset_rolling: got %b expected 0", a_rolling); end
        compared++; if (a_count !== 8'd0) begin mismatched++; $display("FAIL midreset_count: got %0d expected 0", a_count); end
        for (int e = 0; e < 20; e++) begin
            step();
            if (a_done !== 1'b0 || a_rolling !== 1'b0) activity = 1'b1;
        end
        compared++; if (activity) begin mismatched++; $display("FAIL midreset_activity: got 1 expected 0"); end

        // Held button across a reset needs a fresh debounce and press edge.
        roll_btn = 1'b1;
        for (int e = 0; e <= 10; e++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 7) begin
                compared++; if (a_rolling !== 1'b0) begin mismatched++; $display("FAIL held_rise_early: got %b expected 0", a_rolling); end
            end
            if (j == 8) begin
                compared++; if (a_rolling !== 1'b1) begin mismatched++; $display("FAIL held_rise: got %b expected 1", a_rolling); end
            end
        end
        roll_btn = 1'b0;
        for (int e = 0; e < 40; e++) begin
            step();
            if (a_done === 1'b1) pulses++;
        end
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL held_done_pulses: got %0d expected 1", pulses); end
        compared++; if (a_count !== 8'd1) begin mismatched++; $display("FAIL held_count: got %0d expected 1", a_count); end
    endtask

    task automatic test_wrap_and_stability();
        int rise_e, upd_e, done_e, pulses;
        logic [7:0] dv;
        logic [7:0] prev = 8'd0;
        logic [5:0] seen = 6'd0;
        bit stable_ok, range_ok;
        bit bad_done = 1'b0, bad_count = 1'b0, bad_stable = 1'b0, bad_range = 1'b0;

        apply_reset();
        for (int i = 0; i < 600; i++) begin
            run_roll(10 + i % 7, prev, rise_e, upd_e, done_e, pulses, dv, stable_ok, range_ok);
            if (done_e < 0 || pulses != 1) bad_done = 1'b1;
            if (a_count !== 8'(i + 1)) bad_count = 1'b1;
            if (!stable_ok) bad_stable = 1'b1;
            if (!range_ok || dv < 8'd1 || dv > 8'd6) bad_range = 1'b1;
            else seen[dv - 8'd1] = 1'b1;
            prev = dv;
            if (i == 255) begin
                compared++; if (a_count !== 8'd0) begin mismatched++; $display("FAIL wrap_count_256: got %0d expected 0", a_count); end
            end
        end
        compared++; if (bad_done) begin mismatched++; $display("FAIL wrap_done: got missing/extra pulse expected one per roll"); end
        compared++; if (bad_count) begin mismatched++; $display("FAIL wrap_count_seq: got wrong count expected (n+1) mod 256"); end
        compared++; if (bad_stable) begin mismatched++; $display("FAIL wrap_hold_stable: got change in HOLD expected stable"); end
        compared++; if (bad_range) begin mismatched++; $display("FAIL wrap_range: got out-of-range face expected 1..6"); end
        compared++; if (seen !== 6'h3F) begin mismatched++; $display("FAIL wrap_faces_seen: got %b expected 111111", seen); end
        compared++; if (a_count !== 8'd88) begin mismatched++; $display("FAIL wrap_final_count_a: got %0d expected 88", a_count); end
        compared++; if (b_count !== 8'd88) begin mismatched++; $display("FAIL wrap_final_count_b: got %0d expected 88", b_count); end
    endtask

    // dut_b: entry to ROLLING at edge 7, ticks on every odd edge 9..31, SETTLE from 27, done at 31.
    task automatic test_reference_model();
        logic [7:0] exp_v = 8'd0;
        logic       exp_r;
        logic       exp_d;

        apply_reset();
        for (int e = 0; e <= 35; e++) begin
            roll_btn = (e < 20);
            step();
            if (e >= 9 && e <= 31 && (e % 2) == 1) exp_v = last_face;
            exp_r = (e >= 7 && e <= 30);
            exp_d = (e == 31);
            compared++; if (b_value !== exp_v) begin mismatched++; $display("FAIL model_value e=%0d: got %0d expected %0d", e, b_value, exp_v); end
            compared++; if (b_rolling !== exp_r) begin mismatched++; $display("FAIL model_rolling e=%0d: got %b expected %b", e, b_rolling, exp_r); end
            compared++; if (b_done !== exp_d) begin mismatched++; $display("FAIL model_done e=%0d: got %b expected %b", e, b_done, exp_d); end
        end
        compared++; if (b_count !== 8'd1) begin mismatched++; $display("FAIL model_count: got %0d expected 1", b_count); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bounce();
        test_enable_gating();
        test_basic_roll();
        test_reset_mid_roll();
        test_wrap_and_stability();
        test_reference_model();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
